// File: rtl/pc_pkg.sv
// Shared types and defaults for the IF-stage program-counter unit.
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_e;

    localparam int unsigned PC_STEP_DEF  = 32'd4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Low-bit mask covering log2(step) bits; step must be a power of two.
    function automatic logic [31:0] align_mask(input int unsigned step);
        logic [63:0] one_hot;
        one_hot = 64'd1 << $clog2(step);
        return 32'(one_hot - 64'd1);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux for the IF stage.
// Misaligned-redirect detection exists only when PC_MISALIGN_TRAP_EN is defined.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned N_BITS  = 32,
    parameter int unsigned PC_STEP = PC_STEP_DEF
) (
    input  logic [N_BITS-1:0] pc_plus,
    input  logic              branch_taken,
    input  logic [N_BITS-1:0] branch_target,
    input  logic              jump,
    input  logic [N_BITS-1:0] jump_target,
    output logic [N_BITS-1:0] next_pc,
    output logic              misaligned
);

    // Branch belongs to the older instruction, so it wins over a jump.
    always_comb begin
        next_pc = pc_plus;
        if (branch_taken) begin
            next_pc = branch_target;
        end else if (jump) begin
            next_pc = jump_target;
        end else begin
            next_pc = pc_plus;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [N_BITS-1:0] ALIGN_MASK = N_BITS'(align_mask(PC_STEP));

    // When a redirect is selected, next_pc is the redirect target.
    assign misaligned = (branch_taken | jump) & ((next_pc & ALIGN_MASK) != {N_BITS{1'b0}});
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, incrementer, redirect priority, stall, halt, single-step.
// Optional misaligned-redirect trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned       N_BITS   = 32,
    parameter int unsigned       PC_STEP  = PC_STEP_DEF,
    parameter logic [N_BITS-1:0] RESET_PC = N_BITS'(RESET_PC_DEF)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [N_BITS-1:0] i_branch_target,
    input  logic              i_jump,
    input  logic [N_BITS-1:0] i_jump_target,
    input  logic              i_halt,
    input  logic              i_step_mode,
    input  logic              i_step,
    output logic [N_BITS-1:0] o_pc,
    output logic [N_BITS-1:0] o_pc_plus,
    output logic              o_halted,
    output logic              o_misaligned
);

    pc_state_e         state_r;
    pc_state_e         state_next_s;
    logic [N_BITS-1:0] pc_r;
    logic [N_BITS-1:0] pc_next_s;
    logic [N_BITS-1:0] sel_pc_s;
    logic              sel_misaligned_s;
    logic              adv_s;
    logic              accept_s;
    logic              halted_r;

    assign adv_s     = i_enable & ~i_stall & (~i_step_mode | i_step);
    assign accept_s  = (state_r == RUN) & adv_s;
    assign o_pc_plus = pc_r + N_BITS'(PC_STEP);
    assign o_pc      = pc_r;
    assign o_halted  = halted_r;

    pc_next_sel #(
        .N_BITS (N_BITS),
        .PC_STEP(PC_STEP)
    ) u_next_sel (
        .pc_plus      (o_pc_plus),
        .branch_taken (i_branch_taken),
        .branch_target(i_branch_target),
        .jump         (i_jump),
        .jump_target  (i_jump_target),
        .next_pc      (sel_pc_s),
        .misaligned   (sel_misaligned_s)
    );

    // State register with PC and halt flag; reset wins over everything.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_r  <= IDLE;
            pc_r     <= RESET_PC;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            pc_r     <= pc_next_s;
            halted_r <= (state_next_s == HALTED);
        end
    end

    // Next-state logic; HALTED is only left through reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_enable) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (accept_s && (i_halt || sel_misaligned_s)) begin
                    state_next_s = HALTED;
                end else begin
                    state_next_s = RUN;
                end
            end
            HALTED:  state_next_s = HALTED;
            default: state_next_s = IDLE;
        endcase
    end

    // Next PC: only an accepted, non-halting, aligned advance moves the PC.
    always_comb begin
        pc_next_s = pc_r;
        if (accept_s && !i_halt && !sel_misaligned_s) begin
            pc_next_s = sel_pc_s;
        end else begin
            pc_next_s = pc_r;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic misaligned_r;

    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            misaligned_r <= 1'b0;
        end else if (accept_s && !i_halt && sel_misaligned_s) begin
            misaligned_r <= 1'b1;
        end else begin
            misaligned_r <= misaligned_r;
        end
    end

    assign o_misaligned = misaligned_r;
`else
    assign o_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: driver pushes model expectations, monitor pops and compares.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] bt = 32'h0;
    logic        jmp = 1'b0;
    logic [31:0] jt = 32'h0;
    logic        hlt = 1'b0;
    logic        smode = 1'b0;
    logic        step = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        halted;
    logic        mis;

    typedef struct {
        logic [31:0] pc;
        logic        halted;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;

    // Reference model state (behavioural, from the rules)
    bit      m_running = 1'b0;
    bit      m_halted = 1'b0;
    bit      m_mis = 1'b0;
    longint  m_pc = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_enable       (en),
        .i_stall        (stall),
        .i_branch_taken (br),
        .i_branch_target(bt),
        .i_jump         (jmp),
        .i_jump_target  (jt),
        .i_halt         (hlt),
        .i_step_mode    (smode),
        .i_step         (step),
        .o_pc           (pc),
        .o_pc_plus      (pc_plus),
        .o_halted       (halted),
        .o_misaligned   (mis)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Model step for one clock edge with the inputs currently applied.
    task automatic model_edge();
        longint tgt;
        bit     redir;
        if (!rst_n) begin
            m_pc = 0; m_running = 0; m_halted = 0; m_mis = 0;
        end else if (m_halted) begin
            m_pc = m_pc;
        end else if (!m_running) begin
            m_running = en;
        end else if (en && !stall && (!smode || step)) begin
            if (hlt) begin
                m_halted = 1;
            end else begin
                redir = br || jmp;
                tgt = br ? longint'(bt) : longint'(jt);
`ifdef PC_MISALIGN_TRAP_EN
                if (redir && (tgt % 4 != 0)) begin
                    m_halted = 1;
                    m_mis = 1;
                end else
`endif
                m_pc = redir ? tgt : (m_pc + 4) % (64'd1 << 32);
            end
        end
    endtask

    task automatic drive(input logic r, input logic e_i, input logic s_i, input logic b_i,
                         input logic [31:0] bt_i, input logic j_i, input logic [31:0] jt_i,
                         input logic h_i, input logic sm_i, input logic st_i);
        exp_t x;
        @(negedge clk);
        rst_n = r; en = e_i; stall = s_i; br = b_i; bt = bt_i;
        jmp = j_i; jt = jt_i; hlt = h_i; smode = sm_i; step = st_i;
        model_edge();
        x.pc = m_pc[31:0];
        x.halted = m_halted;
        x.mis = m_mis;
        sb.push_back(x);
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every edge produces an output; compare it shortly after the edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pc", pc, e.pc);
            check("pc_plus", pc_plus, e.pc + 32'd4);
            check("halted", {31'd0, halted}, {31'd0, e.halted});
            check("misaligned", {31'd0, mis}, {31'd0, e.mis});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        run_n(5);                                   // 0 (transition), 4, 8, 12, 16
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h30, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h50, 1'b1, 32'h60, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h70, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        run_n(2);
        do_reset();
        // Step mode and wrap near the top of the address space.
        run_n(1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        end
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        run_n(2);
        // Misaligned jump.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h42, 1'b0, 1'b0, 1'b0);
        run_n(3);
        do_reset();
        // Randomised traffic with occasional halts and resets.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rb;
            logic [31:0] rj;
            rb = $urandom();
            rj = $urandom();
            if ($urandom_range(0, 7) != 0) rb[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) rj[1:0] = 2'b00;
            drive(($urandom_range(0, 40) != 0), ($urandom_range(0, 5) != 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), rb,
                  ($urandom_range(0, 3) == 0), rj, ($urandom_range(0, 60) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 0));
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
